// File: rtl/coco_rr_mux.sv
// Purpose: CH-to-1 channel mux with a single registered output slot. The grant comes
//          from an external select (mode=0) or from a round-robin arbiter (mode=1).
// Latency: 1 cycle from the accepting edge to out_valid with the new word.
// Backpressure: out_ready=0 with a held word drops every in_ready. A drain and a load
//               in the same cycle replace the word without a bubble.
// Ports: clk/rst_n  - clock and async active-low reset
//        in_data/in_valid/in_ready - flattened channel inputs, channel i at [i*W +: W]
//        mode/sel   - grant policy and the external channel index
//        out_data/out_valid/out_ready/out_ch - output slot and its source channel
module coco_rr_mux #(
    parameter int W  = 32,
    parameter int CH = 4,
    parameter int SW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_ch
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [SW-1:0] last_q, last_d;

    logic          load_en;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic [W-1:0]  gnt_dat;
    logic          xfer;

    // The slot can take a new word when it is empty or is being drained this cycle.
    assign load_en = !out_valid_q || out_ready;

    // Grant selection. gnt_idx only ever takes values below CH, so neither last
    // nor out_ch can be loaded with an unused index.
    always_comb begin
        int target;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        target  = 0;
        if (!mode) begin
            // A sel value of CH or above matches no channel, so nothing is granted.
            for (int i = 0; i < CH; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end else begin
            // Search from last+1 upward with wrap. The previous winner is checked
            // last, so it has the lowest priority.
            for (int k = 1; k <= CH; k++) begin
                target = (int'(last_q) + k) % CH;
                for (int i = 0; i < CH; i++) begin
                    if (!gnt_vld && i == target && in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SW'(i);
                    end
                end
            end
        end
    end

    // Mux the granted channel's data.
    always_comb begin
        gnt_dat = '0;
        for (int i = 0; i < CH; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_dat = in_data[i*W +: W];
            end
        end
    end

    // in_ready is gated by rst_n so that it stays low while reset is held,
    // including when the slot looks empty.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CH; i++) begin
            in_ready[i] = rst_n && load_en && gnt_vld && (gnt_idx == SW'(i));
        end
    end

    assign xfer = gnt_vld && load_en;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (xfer) begin
            out_data_d  = gnt_dat;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            last_d      = gnt_idx;
        end else if (out_ready) begin
            // The word is drained. Data and channel keep their last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SW'(CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_coco_rr_mux.sv
// Randomised and directed bench for coco_rr_mux. It uses a queue-based scoreboard and
// a behavioural grant model. A second instance with CH=3 covers the sel >= CH case.
module tb_coco_rr_mux;
    localparam int W  = 32;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk;
    logic            rst_n;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_ch;

    // Three-channel instance. Its sel is held at 3, which is out of range.
    logic [3*W-1:0]  in_data_b;
    logic [2:0]      in_valid_b;
    logic [2:0]      in_ready_b;
    logic            mode_b;
    logic [SW-1:0]   sel_b;
    logic [W-1:0]    out_data_b;
    logic            out_valid_b;
    logic            out_ready_b;
    logic [SW-1:0]   out_ch_b;

    coco_rr_mux #(.W(W), .CH(CH), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    coco_rr_mux #(.W(W), .CH(3), .SW(SW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .mode(mode_b), .sel(sel_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_ch(out_ch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard entries are {data, channel} in transfer order.
    logic [W+SW-1:0] exp_q[$];

    // Reference state.
    bit m_ov;
    int m_last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected grant taken straight from the arbitration rules: -1 means no grant.
    function automatic int model_grant(input bit md, input int s, input logic [CH-1:0] v,
                                       input int last);
        if (!md) return (s < CH && v[s]) ? s : -1;
        for (int k = 1; k <= CH; k++) begin
            int idx;
            idx = (last + k) % CH;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [CH*W-1:0] rnd_data();
        logic [CH*W-1:0] d;
        for (int i = 0; i < CH; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    // Monitor. It checks the held word against the scoreboard head and pops the
    // head when the word is consumed.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", 64'(out_valid), 64'd0);
            end else begin
                chk("sb_data", 64'(out_data), 64'(exp_q[0][W+SW-1:SW]));
                chk("sb_ch", 64'(out_ch), 64'(exp_q[0][SW-1:0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One cycle. Entered and left at posedge+1.
    task automatic step(input bit md, input int s, input logic [CH-1:0] v, input bit rdy,
                        input logic [CH*W-1:0] d);
        int g;
        bit load;
        logic [CH-1:0] exp_rdy;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        mode = md; sel = SW'(s); in_valid = v; out_ready = rdy; in_data = d;
        #1;
        g = model_grant(md, s, v, m_last);
        load = !m_ov || rdy;
        exp_rdy = '0;
        if (load && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("b_in_ready", 64'(in_ready_b), 64'd0);
        chk("b_out_valid", 64'(out_valid_b), 64'd0);
        if (load && g >= 0) begin
            exp_q.push_back({d[g*W +: W], SW'(g)});
            m_last = g;
            m_ov = 1'b1;
        end else if (rdy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq[5];
        logic [W-1:0] held_d;
        logic [SW-1:0] held_c;
        logic [CH*W-1:0] dv;
        exp_seq = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1; in_data = rnd_data();
        in_data_b = {32'h3, 32'h2, 32'h1}; in_valid_b = 3'b111; mode_b = 1'b0;
        sel_b = 2'd3; out_ready_b = 1'b1;
        m_ov = 1'b0; m_last = CH - 1;

        // Reset values, checked both before and after a clock edge.
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("rst_out_valid_clk", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_in_ready_clk", 64'(in_ready), 64'd0);
        rst_n = 1'b1;

        // Round-robin over four valid channels.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 0, 4'b1111, 1'b1, rnd_data());
            chk("rr_seq_ch", 64'(out_ch), 64'(exp_seq[i]));
            chk("rr_seq_valid", 64'(out_valid), 64'd1);
        end

        // External select of channel 2.
        dv = rnd_data();
        dv[2*W +: W] = 32'hDEADBEEF;
        step(1'b0, 2, 4'b0100, 1'b1, dv);
        chk("sel2_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
        chk("sel2_ch", 64'(out_ch), 64'd2);

        // Hold for five cycles, then release into the next channel with no bubble.
        held_d = out_data; held_c = out_ch;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 0, 4'b1111, 1'b0, rnd_data());
            chk("hold_data", 64'(out_data), 64'(held_d));
            chk("hold_ch", 64'(out_ch), 64'(held_c));
        end
        step(1'b1, 0, 4'b1111, 1'b1, rnd_data());
        chk("release_ch", 64'(out_ch), 64'((int'(held_c) + 1) % CH));
        chk("release_valid", 64'(out_valid), 64'd1);

        // Wrap from last=1 to channel 0, then drain.
        step(1'b0, 1, 4'b0010, 1'b1, rnd_data());
        step(1'b1, 0, 4'b0001, 1'b1, rnd_data());
        chk("wrap_ch", 64'(out_ch), 64'd0);
        step(1'b1, 0, 4'b0000, 1'b1, rnd_data());
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_ch_kept", 64'(out_ch), 64'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 CH'($urandom), ($urandom_range(0, 9) < 7), rnd_data());
        end

        // Reset asserted between clock edges while a word is held.
        step(1'b1, 0, 4'b1111, 1'b0, rnd_data());
        step(1'b1, 0, 4'b1111, 1'b0, rnd_data());
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_ov = 1'b0; m_last = CH - 1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 0, 4'b1111, 1'b1, rnd_data());
        chk("postrst_ch", 64'(out_ch), 64'd0);

        // Flush the scoreboard.
        step(1'b1, 0, 4'b0000, 1'b1, rnd_data());
        step(1'b1, 0, 4'b0000, 1'b1, rnd_data());
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/coco_rr_mux.md
COCO_RR_MUX -- requirements
Module: coco_rr_mux

Interface
REQ-001 Parameter W, default 32, data width per channel in bits (1..64).
REQ-002 Parameter CH, default 4, number of input channels (2..8).
REQ-003 Parameter SW, default 2, select/channel-index width in bits; CH <= 2**SW.
REQ-004 The clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  CH*W  flattened inputs; channel i occupies bits [i*W+W-1 : i*W].
REQ-008 in_valid  input  CH  per-channel valid; bit i belongs to channel i.
REQ-009 in_ready  output  CH  per-channel ready; at most one bit high in any cycle.
REQ-010 mode  input  1  0 = external select, 1 = round-robin arbitration.
REQ-011 sel  input  SW  channel index used when mode=0.
REQ-012 out_data  output  W  registered selected data.
REQ-013 out_valid  output  1  out_data/out_ch hold an unconsumed word.
REQ-014 out_ready  input  1  downstream accepts the word when out_valid=1.
REQ-015 out_ch  output  SW  index of the channel that supplied out_data.

Function
REQ-016 Output stage SHALL be a single register slot; load_en = !out_valid || out_ready.
REQ-017 Mode 0: grant SHALL be channel sel iff sel < CH and in_valid[sel]=1; otherwise no grant.
REQ-018 Mode 0 with sel >= CH SHALL produce no grant, all in_ready low, and no state change other than draining.
REQ-019 Mode 1: grant SHALL be the first channel with in_valid=1, searched from (last+1) mod CH upward, wrapping; no grant if no in_valid bit is set.
REQ-020 in_ready[i] SHALL be 1 iff load_en=1 and channel i is granted; in_ready is combinational from in_valid, mode, sel, last and the output state.
REQ-021 A transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-022 On a transfer: out_data <= channel i data, out_ch <= i, out_valid <= 1, last <= i, in both modes.
REQ-023 If out_valid=1, out_ready=1 and no transfer occurs, out_valid SHALL go 0; out_data and out_ch SHALL keep their values.
REQ-024 If out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL stay stable and all in_ready SHALL be low.
REQ-025 Simultaneous drain and transfer in the same cycle SHALL replace the word with no bubble, giving one word per cycle throughput.
REQ-026 Latency SHALL be 1 cycle from the transfer edge to out_valid=1 with the new data.
REQ-027 A mode or sel change SHALL take effect on grant in the same cycle; it SHALL NOT alter a word already held in the output slot.
REQ-028 The pointer last SHALL wrap from CH-1 to 0; unused index values >= CH SHALL never be loaded into last or out_ch.

Reset
REQ-029 While rst_n=0, the block SHALL hold out_valid=0, out_data=0, out_ch=0, last=CH-1 and in_ready all 0, regardless of clk.
REQ-030 Reset assertion mid-operation SHALL discard the held word immediately and asynchronously.
REQ-031 After reset release, the first round-robin grant SHALL go to the lowest-indexed valid channel, since last=CH-1 gives channel 0 highest priority.

Verification
REQ-032 Reset, then mode=1, CH=4, in_valid=4'b1111, out_ready=1 held -> out_ch sequence 0,1,2,3,0; out_valid=1 every cycle from cycle 1.
REQ-033 mode=0, sel=2, in_valid=4'b0100, in_data ch2=32'hDEADBEEF -> in_ready=4'b0100; next cycle out_data=32'hDEADBEEF, out_ch=2.
REQ-034 mode=0, sel=3 with CH=3 -> in_ready=0 every cycle; out_valid stays 0.
REQ-035 Hold a word with out_ready=0 for 5 cycles while in_valid=4'b1111 -> out_data/out_ch stable and in_ready=0; on the first out_ready=1 cycle, the next channel is loaded with no bubble.
REQ-036 mode=1, last=1, in_valid=4'b0001 -> grant goes to channel 0 (wrap); then in_valid=0 and out_ready=1 -> out_valid drops to 0 next cycle.
REQ-037 Assert rst_n=0 between clock edges while out_valid=1 -> out_valid=0 and in_ready=0 immediately; after release, a round-robin grant goes to channel 0.
